demux1to4_32bit_buf: RTL

DEMUX1TO4_32BIT_BUF -- requirements
Module: demux1to4_32bit_buf

---
 rtl/demux1to4_32bit_buf_pkg.sv | 19 +
 rtl/demux_slot_32bit.sv | 28 ++
 rtl/demux1to4_32bit_buf.sv | 53 +++++
 3 files changed

// File: rtl/demux1to4_32bit_buf_pkg.sv
// Shared constants and the select decoder for the 1-to-4 buffered demux.
package demux1to4_32bit_buf_pkg;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;
  localparam int SEL_W  = 2;

  // One-hot decode of a channel index, gated by an enable.
  function automatic logic [NCH-1:0] sel_decode(input logic [SEL_W-1:0] sel,
                                                input logic             en);
    logic [NCH-1:0] dec;
    dec = '0;
    for (int i = 0; i < NCH; i++) begin
      dec[i] = en && (sel == SEL_W'(i));
    end
    return dec;
  endfunction

endpackage

// File: rtl/demux_slot_32bit.sv
// One-entry holding register with a full flag. A load always wins over a
// drain, so a same-cycle drain+refill keeps the slot full with no bubble.
module demux_slot_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data_q,
  output logic             full_q
);

  // Holding register and full flag; drain requests on an empty slot are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= load_data;
      full_q <= 1'b1;
    end else if (drain && full_q) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_32bit_buf.sv
// 1-to-4 demultiplexer with a one-word buffer per output channel.
// Each channel is an independent valid/ready stage; a stalled channel only
// blocks words addressed to it.
module demux1to4_32bit_buf
  import demux1to4_32bit_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
);

  logic [NCH-1:0]   full_q;
  logic [NCH-1:0]   load_en;
  logic [WIDTH-1:0] data_q [NCH];
  logic             accept;

  // Selected channel can take a word if empty or being drained this cycle.
  always_comb begin
    in_ready = !full_q[in_sel] || out_ready[in_sel];
    accept   = in_valid && in_ready;
    load_en  = sel_decode(in_sel, accept);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_slot
      demux_slot_32bit #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_en[gi]),
        .load_data(in_data),
        .drain    (out_ready[gi]),
        .data_q   (data_q[gi]),
        .full_q   (full_q[gi])
      );

      assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
      assign out_valid[gi]               = full_q[gi];
    end
  endgenerate

endmodule
